// File: rtl/udma_ts_tx_gen.sv
// Transmit-side timestamp generator: fetches 32-bit words from a uDMA TX channel
// and replays them as paced toggle-valid samples (chid + data) on the timestamp bus.
module udma_ts_tx_gen #(
  parameter int TS_DATA_WIDTH = 28,
  parameter int TS_CHID_LSB   = 28,
  parameter int TS_CHID_WIDTH = 4,
  parameter int GAP_WIDTH     = 8,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                     sys_clk_i,
  input  logic                     rst_ni,
  input  logic                     cfg_en_i,
  input  logic                     cfg_clr_i,
  input  logic [GAP_WIDTH-1:0]     cfg_gap_i,
  output logic                     data_tx_req_o,
  input  logic                     data_tx_gnt_i,
  output logic [1:0]               data_tx_datasize_o,
  input  logic [31:0]              data_tx_i,
  input  logic                     data_tx_valid_i,
  output logic                     data_tx_ready_o,
  output logic                     ts_valid_o,
  output logic [TS_CHID_WIDTH-1:0] ts_chid_o,
  output logic [TS_DATA_WIDTH-1:0] ts_data_o,
  output logic                     event_o,
  output logic [15:0]              sent_cnt_o,
  output logic                     busy_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t                   r_state, w_state_nxt;
  logic [GAP_WIDTH-1:0]     r_gap_cnt, w_gap_nxt;
  logic [31:0]              r_mem [FIFO_DEPTH];
  logic [AW-1:0]            r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]            r_count, r_outst;
  logic                     r_ts_valid, r_event;
  logic [TS_CHID_WIDTH-1:0] r_ts_chid;
  logic [TS_DATA_WIDTH-1:0] r_ts_data;
  logic [15:0]              r_sent_cnt;

  logic          w_full, w_empty, w_push, w_pop, w_grant;
  logic [CW:0]   w_inflight;
  logic [31:0]   w_head;

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_inflight = (CW+1)'(r_count) + (CW+1)'(r_outst);
  assign w_head     = r_mem[r_rd_ptr];

  // Requests are budgeted against buffered plus granted-but-unreturned words,
  // so every granted word is guaranteed a free slot when it arrives.
  assign data_tx_req_o      = cfg_en_i & (w_inflight < (CW+1)'(FIFO_DEPTH));
  assign data_tx_ready_o    = ~w_full;
  assign data_tx_datasize_o = 2'b10;

  assign w_grant = data_tx_req_o & data_tx_gnt_i;
  assign w_push  = data_tx_valid_i & ~w_full;
  assign w_pop   = (r_state == ST_IDLE) & cfg_en_i & ~w_empty & ~cfg_clr_i;

  assign busy_o = (r_state == ST_HOLD) | ~w_empty | (r_outst != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge sys_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outst <= '0;
    end else begin
      case ({w_grant, w_push})
        2'b10:   r_outst <= r_outst + CW'(1);
        2'b01:   r_outst <= r_outst - CW'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (cfg_clr_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; validity is tracked by the pointers and count,
  // which keeps the array as plain flops/RAM without a reset tree.
  always_ff @(posedge sys_clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_tx_i;
  end

  always_ff @(posedge sys_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

  // NOTE: every always_comb output is given a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    if (cfg_clr_i) begin
      w_state_nxt = ST_IDLE;
      w_gap_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            w_state_nxt = ST_HOLD;
            w_gap_nxt   = cfg_gap_i;
          end
        end
        ST_HOLD: begin
          if (r_gap_cnt == '0) w_state_nxt = ST_IDLE;
          else                 w_gap_nxt   = r_gap_cnt - GAP_WIDTH'(1);
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Sample fields only move on a pop, so the far side never sees data change
  // without a matching valid toggle.
  always_ff @(posedge sys_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ts_valid <= 1'b0;
      r_ts_chid  <= '0;
      r_ts_data  <= '0;
      r_event    <= 1'b0;
      r_sent_cnt <= '0;
    end else if (cfg_clr_i) begin
      r_event    <= 1'b0;
      r_sent_cnt <= '0;
    end else begin
      r_event <= w_pop;
      if (w_pop) begin
        r_ts_valid <= ~r_ts_valid;
        r_ts_data  <= w_head[TS_DATA_WIDTH-1:0];
        r_ts_chid  <= w_head[TS_CHID_LSB +: TS_CHID_WIDTH];
        r_sent_cnt <= r_sent_cnt + 16'd1;
      end
    end
  end

  assign ts_valid_o = r_ts_valid;
  assign ts_chid_o  = r_ts_chid;
  assign ts_data_o  = r_ts_data;
  assign event_o    = r_event;
  assign sent_cnt_o = r_sent_cnt;

endmodule

// File: tb/tb_udma_ts_tx_gen.sv
// Bench for udma_ts_tx_gen: queue-based sample model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_udma_ts_tx_gen;

  localparam int DEPTH = 2;

  logic        sys_clk_i = 1'b0;
  logic        rst_ni;
  logic        cfg_en_i = 1'b0, cfg_clr_i = 1'b0;
  logic [7:0]  cfg_gap_i = '0;
  logic        data_tx_gnt_i = 1'b0, data_tx_valid_i = 1'b0;
  logic [31:0] data_tx_i = '0;
  logic        data_tx_req_o, data_tx_ready_o, ts_valid_o, event_o, busy_o;
  logic [1:0]  data_tx_datasize_o;
  logic [3:0]  ts_chid_o;
  logic [27:0] ts_data_o;
  logic [15:0] sent_cnt_o;

  always #5 sys_clk_i = ~sys_clk_i;

  udma_ts_tx_gen dut (
    .sys_clk_i(sys_clk_i), .rst_ni(rst_ni),
    .cfg_en_i(cfg_en_i), .cfg_clr_i(cfg_clr_i), .cfg_gap_i(cfg_gap_i),
    .data_tx_req_o(data_tx_req_o), .data_tx_gnt_i(data_tx_gnt_i),
    .data_tx_datasize_o(data_tx_datasize_o), .data_tx_i(data_tx_i),
    .data_tx_valid_i(data_tx_valid_i), .data_tx_ready_o(data_tx_ready_o),
    .ts_valid_o(ts_valid_o), .ts_chid_o(ts_chid_o), .ts_data_o(ts_data_o),
    .event_o(event_o), .sent_cnt_o(sent_cnt_o), .busy_o(busy_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a word queue, a count of unreturned grants, and the pacing window.
  logic [31:0] mq[$];
  int          m_out = 0;
  bit          m_hold = 1'b0;
  int          m_gap_left = 0;
  logic        m_valid = 1'b0;
  logic [3:0]  m_chid = '0;
  logic [27:0] m_data = '0;
  logic        m_event = 1'b0;
  logic [15:0] m_cnt = '0;
  bit          ld_cnt = 1'b0;
  int          cyc = 0;

  always @(posedge sys_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mq.delete();
      m_out = 0; m_hold = 1'b0; m_gap_left = 0;
      m_valid = 1'b0; m_chid = '0; m_data = '0; m_event = 1'b0; m_cnt = '0;
    end else begin
      bit grant, push, pop;
      logic [31:0] w;
      cyc++;
      grant = cfg_en_i && (mq.size() + m_out < DEPTH) && data_tx_gnt_i;
      push  = data_tx_valid_i && (mq.size() < DEPTH);
      m_out = m_out + int'(grant) - int'(push);
      if (cfg_clr_i) begin
        mq.delete();
        m_hold = 1'b0; m_gap_left = 0; m_cnt = '0; m_event = 1'b0;
      end else begin
        pop = !m_hold && cfg_en_i && (mq.size() > 0);
        if (m_hold) begin
          if (m_gap_left == 0) m_hold = 1'b0;
          else                 m_gap_left--;
        end
        m_event = pop;
        if (pop) begin
          w = mq.pop_front();
          m_valid    = ~m_valid;
          m_data     = w[27:0];
          m_chid     = w[31:28];
          m_cnt      = m_cnt + 16'd1;
          m_hold     = 1'b1;
          m_gap_left = int'(cfg_gap_i);
        end
        if (push) mq.push_back(data_tx_i);
      end
      if (ld_cnt) m_cnt = 16'hFFFF;
    end
  end

  // Per-cycle comparison plus toggle/event/busy bookkeeping for directed checks.
  int   tog_q[$];
  logic prev_v = 1'b0;
  int   ev_n = 0;
  int   busy_low = 0;
  int   req_viol = 0;

  always @(negedge sys_clk_i) begin
    check("req",      data_tx_req_o,      cfg_en_i && (mq.size() + m_out < DEPTH));
    check("ready",    data_tx_ready_o,    mq.size() < DEPTH);
    check("busy",     busy_o,             m_hold || (mq.size() > 0) || (m_out != 0));
    check("datasize", data_tx_datasize_o, 2'b10);
    check("ts_valid", ts_valid_o,         m_valid);
    check("ts_chid",  ts_chid_o,          m_chid);
    check("ts_data",  ts_data_o,          m_data);
    check("event",    event_o,            m_event);
    check("sent_cnt", sent_cnt_o,         m_cnt);
    if (ts_valid_o !== prev_v) begin
      tog_q.push_back(cyc);
      prev_v = ts_valid_o;
    end
    if (event_o) ev_n++;
    if (!busy_o) busy_low++;
    if ((mq.size() + m_out == DEPTH) && data_tx_req_o) req_viol++;
  end

  // Auto responder: grants while words remain, returns data one cycle later.
  logic [31:0] src[$];
  bit auto_mode = 1'b0;
  int n_granted = 0, n_ret = 0, pend = 0;

  task automatic tick();
    bit g, v;
    #1;
    g = data_tx_req_o && data_tx_gnt_i;
    v = data_tx_valid_i && data_tx_ready_o;
    @(posedge sys_clk_i);
    #2;
    if (auto_mode) begin
      n_granted += int'(g);
      if (v) n_ret++;
      pend = pend + int'(g) - int'(v);
      data_tx_gnt_i   = (n_granted < src.size());
      data_tx_valid_i = (pend > 0);
      data_tx_i       = (n_ret < src.size()) ? src[n_ret] : 32'h0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic start_auto();
    n_granted = 0; n_ret = 0; pend = 0;
    data_tx_gnt_i = (src.size() > 0);
    data_tx_valid_i = 1'b0;
    auto_mode = 1'b1;
  endtask

  task automatic stop_auto();
    auto_mode = 1'b0;
    data_tx_gnt_i = 1'b0;
    data_tx_valid_i = 1'b0;
  endtask

  task automatic check_spacing(input string name, input int exp);
    for (int i = 1; i < tog_q.size(); i++) check(name, tog_q[i] - tog_q[i-1], exp);
  endtask

  task automatic check_reset_values();
    check("rst req",      data_tx_req_o,   1'b0);
    check("rst ready",    data_tx_ready_o, 1'b1);
    check("rst ts_valid", ts_valid_o,      1'b0);
    check("rst ts_chid",  ts_chid_o,       4'h0);
    check("rst ts_data",  ts_data_o,       28'h0);
    check("rst event",    event_o,         1'b0);
    check("rst sent_cnt", sent_cnt_o,      16'h0);
    check("rst busy",     busy_o,          1'b0);
  endtask

  int n_tog;

  initial begin
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #1 check_reset_values();
    run(2);
    rst_ni = 1'b1;
    run(2);

    // Back-to-back samples with no gap.
    cfg_gap_i = 8'd0;
    cfg_en_i  = 1'b1;
    tog_q.delete(); ev_n = 0;
    src = {32'h5ABCDEF0, 32'h3FFFFFFF, 32'hF0000001, 32'hA1234567};
    start_auto();
    run(20);
    stop_auto();
    check("t1 toggles",  tog_q.size(), 4);
    check_spacing("t1 spacing", 2);
    check("t1 events",   ev_n, 4);
    check("t1 ts_valid", ts_valid_o, 1'b0);
    check("t1 sent_cnt", sent_cnt_o, 16'd4);
    check("t1 chid",     ts_chid_o, 4'hA);
    check("t1 data",     ts_data_o, 28'h1234567);

    // Paced samples with a backlog.
    cfg_gap_i = 8'd5;
    tog_q.delete(); req_viol = 0;
    src = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    start_auto();
    run(50);
    stop_auto();
    check("t3 toggles",  tog_q.size(), 4);
    check_spacing("t3 spacing", 7);
    check("t3 req_viol", req_viol, 0);
    check("t3 sent_cnt", sent_cnt_o, 16'd8);
    check("t3 data",     ts_data_o, 28'h4444444);

    // Grants taken, then disable before data returns.
    cfg_gap_i = 8'd0;
    run(3);
    n_tog = tog_q.size();
    data_tx_gnt_i = 1'b1;
    tick();
    busy_low = 0;
    tick();
    data_tx_gnt_i = 1'b0;
    cfg_en_i = 1'b0;
    run(2);
    data_tx_valid_i = 1'b1; data_tx_i = 32'h6000_0AAA;
    tick();
    data_tx_i = 32'h7000_0BBB;
    tick();
    data_tx_valid_i = 1'b0;
    run(5);
    check("t4 no toggle", tog_q.size(), n_tog);
    check("t4 busy held", busy_low, 0);
    check("t4 full",      data_tx_ready_o, 1'b0);
    cfg_en_i = 1'b1;
    run(6);
    cfg_en_i = 1'b0;
    check("t4 toggles",   tog_q.size(), n_tog + 2);
    check("t4 chid",      ts_chid_o, 4'h7);
    check("t4 data",      ts_data_o, 28'h0000BBB);

    // Clear with a full buffer while an IDLE pop would occur.
    cfg_en_i = 1'b1; data_tx_gnt_i = 1'b1;
    tick(); tick();
    data_tx_gnt_i = 1'b0; cfg_en_i = 1'b0;
    data_tx_valid_i = 1'b1; data_tx_i = 32'h1000_0001;
    tick();
    data_tx_i = 32'h2000_0002;
    tick();
    data_tx_valid_i = 1'b0;
    tick();
    n_tog = tog_q.size();
    cfg_en_i = 1'b1; cfg_clr_i = 1'b1;
    tick();
    cfg_clr_i = 1'b0; cfg_en_i = 1'b0;
    run(2);
    check("t5a no toggle", tog_q.size(), n_tog);
    check("t5a sent_cnt",  sent_cnt_o, 16'd0);
    check("t5a ts_valid",  ts_valid_o, 1'b0);
    check("t5a busy",      busy_o, 1'b0);

    // Clear coinciding with a push: the word is dropped and its grant retired.
    cfg_en_i = 1'b1; data_tx_gnt_i = 1'b1;
    tick(); tick();
    data_tx_gnt_i = 1'b0; cfg_en_i = 1'b0;
    data_tx_valid_i = 1'b1; data_tx_i = 32'h3000_0003;
    tick();
    cfg_en_i = 1'b1; cfg_clr_i = 1'b1; data_tx_i = 32'h4000_0004;
    tick();
    cfg_clr_i = 1'b0; cfg_en_i = 1'b0; data_tx_valid_i = 1'b0;
    run(2);
    check("t5b no toggle", tog_q.size(), n_tog);
    check("t5b busy",      busy_o, 1'b0);
    check("t5b ready",     data_tx_ready_o, 1'b1);

    // Clear with a grant outstanding: the late word is still buffered.
    cfg_en_i = 1'b1; data_tx_gnt_i = 1'b1;
    tick();
    data_tx_gnt_i = 1'b0; cfg_en_i = 1'b0; cfg_clr_i = 1'b1;
    tick();
    cfg_clr_i = 1'b0;
    run(2);
    check("t5c busy outst", busy_o, 1'b1);
    data_tx_valid_i = 1'b1; data_tx_i = 32'hC0FF_EE12;
    tick();
    data_tx_valid_i = 1'b0;
    cfg_en_i = 1'b1;
    run(4);
    cfg_en_i = 1'b0;
    check("t5c toggles",  tog_q.size(), n_tog + 1);
    check("t5c chid",     ts_chid_o, 4'hC);
    check("t5c data",     ts_data_o, 28'h0FFEE12);
    check("t5c sent_cnt", sent_cnt_o, 16'd1);

    // Counter wrap from a preloaded 0xFFFF.
    @(negedge sys_clk_i);
    #1;
    force dut.r_sent_cnt = 16'hFFFF;
    ld_cnt = 1'b1;
    @(posedge sys_clk_i);
    #2;
    release dut.r_sent_cnt;
    ld_cnt = 1'b0;
    tick();
    check("t6 preload", sent_cnt_o, 16'hFFFF);
    cfg_en_i = 1'b1;
    src = {32'h9876_5432};
    start_auto();
    run(8);
    stop_auto();
    check("t6 wrap", sent_cnt_o, 16'h0000);

    // Reset in the middle of a long HOLD.
    cfg_gap_i = 8'd20;
    src = {32'hB000_0055};
    start_auto();
    run(6);
    stop_auto();
    check("t6 mid hold busy", busy_o, 1'b1);
    check("t6 mid hold valid", ts_valid_o, 1'b1);
    cfg_en_i = 1'b0;
    rst_ni = 1'b0;
    #1 check_reset_values();
    run(2);
    rst_ni = 1'b1;
    run(3);
    check_reset_values();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
